alu_seq_param: RTL and testbench
================================

// Module: alu_seq_param
// PURPOSE
//   Parametrised, clocked successor to the 4-bit combinational ALU. Operands and
//   opcode are captured on a START handshake. Results and status flags are
//   registered. A multi-cycle shift-add multiply produces a 2*WIDTH product.
//   Used as the execution unit of the lab datapath, driven by the control FSM.
// PARAMETERS
//   WIDTH     4   operand/result width in bits (WIDTH >= 2)
//   CNT_W     $clog2(WIDTH)+1   multiply iteration counter width (derived, not overridden)
// PORTS
//   CLK_in     input   1        system clock, rising edge
//   RST_N_in   input   1        asynchronous active-low reset
//   START_in   input   1        start request; accepted only when BUSY==0
//   A_in       input   WIDTH    operand A
//   B_in       input   WIDTH    operand B
//   SEL_in     input   3        opcode (see BEHAVIOUR)
//   Y          output  WIDTH    result (low half of the product for MUL)
//   Y_HI       output  WIDTH    high half of the product for MUL; 0 for all other ops
//   C_FLAG     output  1        carry (ADD), borrow (SUB); 0 otherwise
//   V_FLAG     output  1        two's-complement overflow (ADD/SUB); 0 otherwise
//   Z_FLAG     output  1        1 when {Y_HI,Y}==0
//   BUSY       output  1        high while a MUL is in progress
//   DONE       output  1        one-cycle pulse: result and flags updated
// BEHAVIOUR
//   - Reset (async, RST_N_in=0): Y, Y_HI, C, V, Z, BUSY, DONE all 0; FSM->IDLE.
//     Reset mid-MUL aborts the operation: no DONE, and the partial product is discarded.
//   - Opcodes: 0 PASS A | 1 ADD | 2 SUB (A-B) | 3 AND | 4 OR | 5 XOR |
//     6 MUL (unsigned) | 7 SHL (A << B; if B >= WIDTH then Y=0)
//   - Accept: START_in=1 and BUSY=0 at rising edge k. A_in/B_in/SEL_in latched at edge k.
//     START_in while BUSY=1 is ignored and is not queued.
//   - FSM states IDLE and MUL.
//     IDLE + accept + SEL!=6: result is computed and registered at edge k.
//       DONE=1 for the cycle following edge k. State stays IDLE (latency 1).
//     IDLE + accept + SEL==6: IDLE->MUL, BUSY=1 from edge k.
//       One shift-add iteration per edge k+1..k+WIDTH.
//       At edge k+WIDTH: {Y_HI,Y} = product, DONE=1, BUSY=0, MUL->IDLE.
//     Back-to-back single-cycle ops: START held high is accepted every cycle.
//       DONE stays high continuously, with new results each cycle.
//     A new START is accepted in the same cycle that MUL's DONE is high (BUSY=0).
//   - Arithmetic: ADD {C,Y}=A+B. SUB {borrow,Y}=A-B, with C=1 when A<B unsigned.
//     V = signed overflow of the WIDTH-bit add/sub.
//   - Logic ops, PASS and SHL: C=0, V=0, Y_HI=0. Z is computed for every op.
//   - Outputs hold their last values between operations.
//   - DONE is never asserted without a preceding accepted START.
// TESTING (WIDTH=4)
//   1. ADD A=10 B=6 -> next cycle: Y=0, C=1, V=0, Z=1, DONE pulse of 1 cycle.
//   2. ADD A=7 B=1 -> Y=8, V=1, C=0. SUB A=3 B=4 -> Y=15, C=1, V=0, Z=0.
//   3. MUL A=13 B=11 -> BUSY for 4 cycles, then Y=4'hF, Y_HI=4'h8, DONE pulse.
//      A START issued mid-MUL is ignored.
//   4. Reset pulse in the 2nd MUL cycle -> all outputs 0 at once. No DONE afterwards.
//      Next ADD 2+3 -> Y=5.
//   5. SHL A=5 B=2 -> Y=4, C=0. SHL B=4 -> Y=0, Z=1.
//      PASS A=6 -> Y=6. XOR 12^10 -> Y=6.
//   6. START held high across ADD, SUB, AND with changing operands ->
//      three consecutive DONE cycles, each carrying the matching result.

Source files
------------

// File: rtl/alu_seq_param.sv
// Clocked ALU with start handshake, registered results/flags and a WIDTH-cycle
// shift-add unsigned multiplier producing a 2*WIDTH product on {Y_HI,Y}.
module alu_seq_param #(
  parameter int WIDTH = 4
) (
  input  logic             CLK_in,
  input  logic             RST_N_in,
  input  logic             START_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [2:0]       SEL_in,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_HI,
  output logic             C_FLAG,
  output logic             V_FLAG,
  output logic             Z_FLAG,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SHAMT_LIM = WIDTH'(WIDTH);

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

  typedef enum logic [2:0] {
    OP_PASS = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_MUL  = 3'd6,
    OP_SHL  = 3'd7
  } op_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_y;
  logic [WIDTH-1:0]     r_y_hi;
  logic                 r_c;
  logic                 r_v;
  logic                 r_z;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;

  op_t                  w_op;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_res;
  logic                 w_c;
  logic                 w_v;
  logic [2*WIDTH-1:0]   w_acc_next;

  assign w_op = op_t'(SEL_in);

  always_comb begin
    w_sum  = {1'b0, A_in} + {1'b0, B_in};
    w_diff = {1'b0, A_in} - {1'b0, B_in};
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    case (w_op)
      OP_PASS: w_res = A_in;
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (A_in[WIDTH-1] == B_in[WIDTH-1]) && (w_sum[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow (A < B).
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (A_in[WIDTH-1] != B_in[WIDTH-1]) && (w_diff[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_AND:  w_res = A_in & B_in;
      OP_OR:   w_res = A_in | B_in;
      OP_XOR:  w_res = A_in ^ B_in;
      OP_SHL:  w_res = (B_in >= SHAMT_LIM) ? '0 : (A_in << B_in);
      default: w_res = '0;
    endcase
  end

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge CLK_in or negedge RST_N_in) begin
    if (!RST_N_in) begin
      r_state  <= ST_IDLE;
      r_y      <= '0;
      r_y_hi   <= '0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_z      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START_in) begin
            if (w_op == OP_MUL) begin
              r_mcand  <= {{WIDTH{1'b0}}, A_in};
              r_mplier <= B_in;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= ST_MUL;
            end else begin
              r_y    <= w_res;
              r_y_hi <= '0;
              r_c    <= w_c;
              r_v    <= w_v;
              r_z    <= (w_res == '0);
              r_done <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          // Final iteration publishes the accumulator including this step's partial product.
          if (r_cnt == CNT_LAST) begin
            {r_y_hi, r_y} <= w_acc_next;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= (w_acc_next == '0);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Y      = r_y;
  assign Y_HI   = r_y_hi;
  assign C_FLAG = r_c;
  assign V_FLAG = r_v;
  assign Z_FLAG = r_z;
  assign BUSY   = r_busy;
  assign DONE   = r_done;

endmodule

// File: tb/tb_alu_seq_param.sv
// Bench for alu_seq_param (WIDTH=4): directed scenarios plus random traffic,
// compared every cycle against an arithmetic reference model.
module tb_alu_seq_param;

  localparam int W = 4;
  localparam int unsigned MOD = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [2:0]   sel;
  logic [W-1:0] y;
  logic [W-1:0] y_hi;
  logic         c_flag;
  logic         v_flag;
  logic         z_flag;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  int unsigned m_y, m_yhi, m_prod;
  int          m_cnt;
  bit          m_c, m_v, m_z, m_busy, m_done;

  alu_seq_param #(.WIDTH(W)) dut (
    .CLK_in  (clk),
    .RST_N_in(rst_n),
    .START_in(start),
    .A_in    (a_in),
    .B_in    (b_in),
    .SEL_in  (sel),
    .Y       (y),
    .Y_HI    (y_hi),
    .C_FLAG  (c_flag),
    .V_FLAG  (v_flag),
    .Z_FLAG  (z_flag),
    .BUSY    (busy),
    .DONE    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_y = 0; m_yhi = 0; m_prod = 0; m_cnt = 0;
    m_c = 0; m_v = 0; m_z = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_step(input bit s, input int unsigned op, input int unsigned a, input int unsigned b);
    int sa, sb, r;
    sa = (a >= HALF) ? int'(a) - int'(MOD) : int'(a);
    sb = (b >= HALF) ? int'(b) - int'(MOD) : int'(b);
    m_done = 0;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_y = m_prod % MOD; m_yhi = m_prod / MOD;
        m_c = 0; m_v = 0; m_z = (m_prod == 0);
        m_done = 1; m_busy = 0;
      end
    end else if (s) begin
      if (op == 6) begin
        m_prod = a * b; m_cnt = W; m_busy = 1;
      end else begin
        m_c = 0; m_v = 0; m_yhi = 0;
        case (op)
          0: m_y = a;
          1: begin
            m_y = (a + b) % MOD; m_c = (a + b) >= MOD;
            r = sa + sb; m_v = (r > HALF - 1) || (r < -HALF);
          end
          2: begin
            m_y = (a + MOD - b) % MOD; m_c = (a < b);
            r = sa - sb; m_v = (r > HALF - 1) || (r < -HALF);
          end
          3: m_y = a & b;
          4: m_y = a | b;
          5: m_y = a ^ b;
          default: m_y = (b >= W) ? 0 : (a << b) % MOD;
        endcase
        m_z = (m_y == 0);
        m_done = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("y",    y,      m_y);
    chk("y_hi", y_hi,   m_yhi);
    chk("c",    c_flag, m_c);
    chk("v",    v_flag, m_v);
    chk("z",    z_flag, m_z);
    chk("busy", busy,   m_busy);
    chk("done", done,   m_done);
  endtask

  task automatic cyc(input bit s, input int unsigned op, input int unsigned a, input int unsigned b);
    start = s; sel = op[2:0]; a_in = a[W-1:0]; b_in = b[W-1:0];
    @(posedge clk);
    model_step(s, op, a, b);
    #1;
    check_all();
    cyc_n++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = '0; a_in = '0; b_in = '0;
    model_reset();
    #2;
    check_all();
    #20 rst_n = 1'b1;

    // ADD overflow to zero with carry
    cyc(1, 1, 10, 6);
    chk("t1_y", y, 0); chk("t1_c", c_flag, 1); chk("t1_v", v_flag, 0);
    chk("t1_z", z_flag, 1); chk("t1_done", done, 1);
    cyc(0, 0, 0, 0);
    chk("t1_done_pulse", done, 0);

    cyc(1, 1, 7, 1);
    chk("t2_add_y", y, 8); chk("t2_add_v", v_flag, 1); chk("t2_add_c", c_flag, 0);
    cyc(1, 2, 3, 4);
    chk("t2_sub_y", y, 15); chk("t2_sub_c", c_flag, 1);
    chk("t2_sub_v", v_flag, 0); chk("t2_sub_z", z_flag, 0);
    cyc(0, 0, 0, 0);

    // MUL with START held (ignored while busy), then accept in the DONE cycle
    cyc(1, 6, 13, 11);
    chk("t3_busy0", busy, 1);
    for (int i = 0; i < W - 1; i++) cyc(1, 1, 1, 1);
    cyc(1, 1, 1, 1);
    chk("t3_y", y, 4'hF); chk("t3_yhi", y_hi, 4'h8);
    chk("t3_done", done, 1); chk("t3_busy", busy, 0);
    cyc(1, 1, 2, 2);
    chk("t3_next_y", y, 4); chk("t3_next_done", done, 1);
    cyc(0, 0, 0, 0);

    // Reset in the second MUL cycle
    cyc(1, 6, 13, 11);
    cyc(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) cyc(0, 0, 0, 0);
    cyc(1, 1, 2, 3);
    chk("t4_y", y, 5);

    cyc(1, 7, 5, 2);  chk("t5_shl_y", y, 4); chk("t5_shl_c", c_flag, 0);
    cyc(1, 7, 5, 4);  chk("t5_shl_big_y", y, 0); chk("t5_shl_big_z", z_flag, 1);
    cyc(1, 0, 6, 9);  chk("t5_pass_y", y, 6);
    cyc(1, 5, 12, 10); chk("t5_xor_y", y, 6);

    cyc(1, 1, 9, 3);   chk("t6_add", y, 12); chk("t6_d0", done, 1);
    cyc(1, 2, 9, 12);  chk("t6_sub", y, 13); chk("t6_d1", done, 1);
    cyc(1, 3, 12, 10); chk("t6_and", y, 8);  chk("t6_d2", done, 1);
    cyc(0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 7), $urandom_range(0, 7),
          $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
